imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Receives a byte stream and writes it into instruction memory while the
// processor core is held in reset. The stream is:
//   length low byte, length high byte (word count),
//   count * 4 data bytes (each word little-endian),
//   one checksum byte (only when IMEM_LOADER_CHECKSUM_EN is defined).
// Once the image is complete the core is released (cpu_reset_n=1, done=1).
// An oversize header or a checksum mismatch leads to the error state, which
// keeps the core in reset. DONE and ERR hold until the next start.
//
// Configuration macro:
//   IMEM_LOADER_CHECKSUM_EN - adds the CHK state and a running XOR of all
//                             data bytes, checked against a trailing byte.
//
// Parameters:
//   ADDR_WIDTH  - instruction-memory word-address width
//   DEPTH_WORDS - largest accepted word count (at most 2**ADDR_WIDTH)
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low reset
//   start        in   one-cycle load request (ignored while a load runs)
//   in_data      in   stream byte
//   in_valid     in   in_data is valid
//   in_ready     out  loader accepts a byte this cycle
//   imem_we      out  one-cycle instruction-memory write strobe
//   imem_addr    out  word address of the current write
//   imem_wdata   out  assembled instruction word
//   cpu_reset_n  out  active-low core hold, 1 only in DONE
//   done         out  image loaded
//   error        out  load aborted
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module imem_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] DepthLimit = 17'(DEPTH_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;
  localparam state_t AfterData = CHK;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;
  localparam state_t AfterData = DONE;
`endif

  state_t      state;
  state_t      nextState;

  logic        accept;
  logic        idleLike;
  logic        lastWordByte;
  logic [15:0] hdrCount;
  logic [15:0] count;
  logic [15:0] wordCnt;
  logic [1:0]  lane;
  logic [23:0] wordBuf;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xorAcc;
`endif

  assign accept       = in_valid & in_ready;
  assign idleLike     = (state == IDLE) || (state == DONE) || (state == ERR);
  // Full length as it will be once the high byte currently on in_data lands.
  assign hdrCount     = {in_data, count[7:0]};
  // Fourth byte of the final word: the load moves on at this very edge, so
  // the write strobe for that word lands in the first cycle of the next state.
  assign lastWordByte = (lane == 2'd3) && ((wordCnt + 16'd1) == count);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is assigned with <= so every flop samples the values
  // from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) nextState = LEN_LO;
      end
      LEN_LO: begin
        if (accept) nextState = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          if (hdrCount == 16'd0)                 nextState = AfterData;
          else if ({1'b0, hdrCount} > DepthLimit) nextState = ERR;
          else                                   nextState = DATA;
        end
      end
      DATA: begin
        if (accept && lastWordByte) nextState = AfterData;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) nextState = (in_data == xorAcc) ? DONE : ERR;
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready    = 1'b0;
    cpu_reset_n = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    case (state)
      LEN_LO, LEN_HI, DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:                  in_ready = 1'b1;
`endif
      DONE: begin
        cpu_reset_n = 1'b1;
        done        = 1'b1;
      end
      ERR:                  error    = 1'b1;
      default:              ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Header, word assembly and write strobe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      wordCnt    <= '0;
      lane       <= '0;
      wordBuf    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (idleLike && start) begin
        count     <= '0;
        wordCnt   <= '0;
        lane      <= '0;
        imem_addr <= '0;
      end else if (accept) begin
        case (state)
          LEN_LO: count[7:0]  <= in_data;
          LEN_HI: count[15:8] <= in_data;
          DATA: begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: wordBuf[7:0]   <= in_data;
              2'd1: wordBuf[15:8]  <= in_data;
              2'd2: wordBuf[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_wdata <= {in_data, wordBuf};
                imem_addr  <= ADDR_WIDTH'(wordCnt);
                wordCnt    <= wordCnt + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over every data byte of the current image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xorAcc <= '0;
    end else if (idleLike && start) begin
      xorAcc <= '0;
    end else if (accept && (state == DATA)) begin
      xorAcc <= xorAcc ^ in_data;
    end
  end
`endif

endmodule
